// File: rtl/md5_stream_ctrl.sv
// md5_stream_ctrl: streaming front-end and block sequencer for md5_core.
// Packs 32-bit message words into 512-bit blocks, appends MD5 padding
// (0x80, zeros, 64-bit little-endian bit length), and pulses core_start for
// the first block of a message or core_resume for later blocks. The digest
// is returned on a valid/ready output.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   abort                     optional; present only with MD5_ABORT_EN defined
//   s_valid/s_ready           input word handshake
//   s_data, s_last, s_bytes   word (first byte in [31:24]), last flag, bytes in last word (0 = 4)
//   core_start, core_resume   one-cycle pulses to md5_core
//   core_block                [0:511] block, message byte k at [8k +: 8]
//   core_done, core_hash      md5_core completion and digest
//   hash, hash_valid          registered digest, held until hash_ready
//   hash_ready                digest consumer ready
//   busy                      high in every state except IDLE
//
// Optional feature macro: MD5_ABORT_EN adds the abort input and its logic.

module md5_stream_ctrl #(
    parameter int unsigned LEN_W = 64
) (
    input  logic           clk,
    input  logic           rst,
`ifdef MD5_ABORT_EN
    input  logic           abort,
`endif
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [31:0]    s_data,
    input  logic           s_last,
    input  logic [1:0]     s_bytes,
    output logic           core_start,
    output logic           core_resume,
    output logic [0:511]   core_block,
    input  logic           core_done,
    input  logic [127:0]   core_hash,
    output logic [127:0]   hash,
    output logic           hash_valid,
    input  logic           hash_ready,
    output logic           busy
);

    localparam int unsigned BLK_W  = 512;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned HASH_W = 128;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_PAD, S_XPAD, S_LAUNCH, S_WAIT, S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [0:BLK_W-1]    block_q, block_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          widx_q, widx_d;
    logic                first_q, first_d;   // next launch is the first block of the message
    logic                final_q, final_d;   // current block carries the length
    logic                extra_q, extra_d;   // one more padding-only block follows
    logic                mark_q, mark_d;     // 0x80 terminator already placed
    logic [HASH_W-1:0]   hash_q, hash_d;
    logic                s_ready_q, s_ready_d;
    logic                core_start_q, core_start_d;
    logic                core_resume_q, core_resume_d;
    logic                hash_valid_q, hash_valid_d;
    logic                busy_q, busy_d;
`ifdef MD5_ABORT_EN
    logic                abort_pend_q, abort_pend_d;
`endif

    logic [63:0]         bit_len;
    logic [63:0]         len_le;
    logic [5:0]          pad_pos;
    logic [WORD_W-1:0]   word_in;
    logic [2:0]          add_bytes;

    assign bit_len = 64'({cnt_q, 3'b000});
    assign pad_pos = cnt_q[5:0];

    // Length bytes in block order: LSB lands at byte 56.
    always_comb begin
        len_le = '0;
        for (int i = 0; i < 8; i++) begin
            len_le[63-8*i -: 8] = bit_len[8*i +: 8];
        end
    end

    // Zero the unused trailing bytes of a short final word so padding stays clean.
    always_comb begin
        word_in   = s_data;
        add_bytes = 3'd4;
        if (s_last && (s_bytes != 2'd0)) begin
            add_bytes = {1'b0, s_bytes};
            unique case (s_bytes)
                2'd1:    word_in = {s_data[31:24], 24'h0};
                2'd2:    word_in = {s_data[31:16], 16'h0};
                default: word_in = {s_data[31:8], 8'h0};
            endcase
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        block_d = block_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        first_d = first_q;
        final_d = final_q;
        extra_d = extra_q;
        mark_d  = mark_q;
        hash_d  = hash_q;
`ifdef MD5_ABORT_EN
        abort_pend_d = abort_pend_q;
`endif

        unique case (state_q)
            S_IDLE, S_FILL: begin
                if (s_valid) begin
                    if (widx_q == 4'd0) begin
                        block_d = '0;
                    end
                    block_d[{widx_q, 5'b00000} +: 32] = word_in;
                    widx_d = widx_q + 4'd1;
                    cnt_d  = cnt_q + LEN_W'(add_bytes);
                    if (s_last) begin
                        state_d = S_PAD;
                    end else if (widx_q == 4'd15) begin
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_PAD: begin
                // n == 0 means the last word filled the block: send it raw, pad in XPAD.
                if (pad_pos == 6'd0) begin
                    extra_d = 1'b1;
                end else begin
                    block_d[{pad_pos, 3'b000} +: 8] = 8'h80;
                    mark_d = 1'b1;
                    if (pad_pos <= 6'd55) begin
                        block_d[448 +: 64] = len_le;
                        final_d = 1'b1;
                    end else begin
                        extra_d = 1'b1;
                    end
                end
                state_d = S_LAUNCH;
            end
            S_XPAD: begin
                block_d = '0;
                if (!mark_q) begin
                    block_d[0 +: 8] = 8'h80;
                end
                block_d[448 +: 64] = len_le;
                mark_d  = 1'b1;
                final_d = 1'b1;
                extra_d = 1'b0;
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                first_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Entered the cycle after the pulse, so a stale done from the previous run is gone.
                if (core_done) begin
                    if (final_q) begin
                        state_d = S_OUT;
                        hash_d  = core_hash;
                    end else if (extra_q) begin
                        state_d = S_XPAD;
                    end else begin
                        state_d = S_FILL;
                        widx_d  = '0;
                    end
                end
            end
            S_OUT: begin
                if (hash_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    widx_d  = '0;
                    first_d = 1'b1;
                    final_d = 1'b0;
                    extra_d = 1'b0;
                    mark_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef MD5_ABORT_EN
        // An in-flight core run is allowed to finish; its result is then dropped.
        if ((abort && (state_q != S_LAUNCH) && (state_q != S_WAIT)) ||
            ((state_q == S_WAIT) && core_done && (abort || abort_pend_q))) begin
            state_d      = S_IDLE;
            block_d      = '0;
            cnt_d        = '0;
            widx_d       = '0;
            first_d      = 1'b1;
            final_d      = 1'b0;
            extra_d      = 1'b0;
            mark_d       = 1'b0;
            hash_d       = hash_q;
            abort_pend_d = 1'b0;
        end else if (abort) begin
            abort_pend_d = 1'b1;
        end
`endif

        s_ready_d     = (state_d == S_IDLE) || (state_d == S_FILL);
        core_start_d  = (state_d == S_LAUNCH) && first_q;
        core_resume_d = (state_d == S_LAUNCH) && !first_q;
        hash_valid_d  = (state_d == S_OUT);
        busy_d        = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            block_q       <= '0;
            cnt_q         <= '0;
            widx_q        <= '0;
            first_q       <= 1'b1;
            final_q       <= 1'b0;
            extra_q       <= 1'b0;
            mark_q        <= 1'b0;
            hash_q        <= '0;
            s_ready_q     <= 1'b1;
            core_start_q  <= 1'b0;
            core_resume_q <= 1'b0;
            hash_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
`ifdef MD5_ABORT_EN
            abort_pend_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            block_q       <= block_d;
            cnt_q         <= cnt_d;
            widx_q        <= widx_d;
            first_q       <= first_d;
            final_q       <= final_d;
            extra_q       <= extra_d;
            mark_q        <= mark_d;
            hash_q        <= hash_d;
            s_ready_q     <= s_ready_d;
            core_start_q  <= core_start_d;
            core_resume_q <= core_resume_d;
            hash_valid_q  <= hash_valid_d;
            busy_q        <= busy_d;
`ifdef MD5_ABORT_EN
            abort_pend_q  <= abort_pend_d;
`endif
        end
    end

    assign s_ready     = s_ready_q;
    assign core_start  = core_start_q;
    assign core_resume = core_resume_q;
    assign core_block  = block_q;
    assign hash        = hash_q;
    assign hash_valid  = hash_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_md5_stream_ctrl.sv
// Testbench for md5_stream_ctrl with a behavioural md5_core model
// (68-cycle start latency, 67-cycle resume latency, done held until the next pulse).
module tb_md5_stream_ctrl;

    typedef logic [7:0] byte_t;
    typedef struct packed {
        logic         start;
        logic [511:0] blk;
    } exp_blk_t;

    localparam logic [127:0] IV       = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
    localparam logic [127:0] ABC_HASH = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] A56_HASH = 128'h3b0c8ac703f828b04c6c197006d17218;
    localparam logic [511:0] ABC_BLK  = {32'h61626380, 416'h0, 8'h18, 56'h0};
    localparam logic [511:0] A56_BLK2 = {448'h0, 8'hC0, 8'h01, 48'h0};

    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    localparam int S_TAB [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid, s_ready, s_last;
    logic [31:0]  s_data;
    logic [1:0]   s_bytes;
    logic         core_start, core_resume, core_done;
    logic [0:511] core_block;
    logic [127:0] core_hash, hash;
    logic         hash_valid, hash_ready, busy;
`ifdef MD5_ABORT_EN
    logic         abort;
`endif

    int errors = 0;
    int checks = 0;

    exp_blk_t     exp_blk[$];
    logic [127:0] exp_hash[$];
    logic [511:0] got_blks[$];
    logic [127:0] last_hash;
    int           n_start = 0;
    int           n_resume = 0;

    always #5 clk = ~clk;

    md5_stream_ctrl dut (
        .clk         (clk),
        .rst         (rst),
`ifdef MD5_ABORT_EN
        .abort       (abort),
`endif
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_bytes     (s_bytes),
        .core_start  (core_start),
        .core_resume (core_resume),
        .core_block  (core_block),
        .core_done   (core_done),
        .core_hash   (core_hash),
        .hash        (hash),
        .hash_valid  (hash_valid),
        .hash_ready  (hash_ready),
        .busy        (busy)
    );

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [127:0] md5_digest(input logic [127:0] st);
        return {bswap(st[127:96]), bswap(st[95:64]), bswap(st[63:32]), bswap(st[31:0])};
    endfunction

    // Block held with message byte k at [511-8k -: 8].
    function automatic logic [127:0] md5_compress(input logic [127:0] st, input logic [511:0] blk);
        logic [31:0] m [16];
        logic [31:0] a, b, c, d, f, t;
        int g, s;
        for (int j = 0; j < 16; j++) begin
            m[j] = {blk[511-8*(4*j+3) -: 8], blk[511-8*(4*j+2) -: 8],
                    blk[511-8*(4*j+1) -: 8], blk[511-8*(4*j) -: 8]};
        end
        a = st[127:96]; b = st[95:64]; c = st[63:32]; d = st[31:0];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0:       begin f = (b & c) | (~b & d); g = i;               end
                1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            endcase
            s = S_TAB[(i / 16) * 4 + (i % 4)];
            f = f + a + K_TAB[i] + m[g];
            t = d; d = c; c = b;
            b = b + ((f << s) | (f >> (32 - s)));
            a = t;
        end
        return {st[127:96] + a, st[95:64] + b, st[63:32] + c, st[31:0] + d};
    endfunction

    // md5_core model
    logic [127:0] cm_st;
    int           cm_cnt;
    logic         cm_busy;
    always @(posedge clk) begin
        if (rst) begin
            core_done <= 1'b0;
            core_hash <= '0;
            cm_busy   <= 1'b0;
            cm_cnt    <= 0;
            cm_st     <= IV;
        end else if (core_start || core_resume) begin
            cm_st     <= md5_compress(core_start ? IV : cm_st, core_block);
            core_done <= 1'b0;
            cm_busy   <= 1'b1;
            cm_cnt    <= core_start ? 67 : 66;
        end else if (cm_busy) begin
            if (cm_cnt == 1) begin
                core_done <= 1'b1;
                core_hash <= md5_digest(cm_st);
                cm_busy   <= 1'b0;
            end else begin
                cm_cnt <= cm_cnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT launches a block or hands off a digest.
    logic [511:0] launched;
    bit           wait_chk = 1'b0;
    exp_blk_t     e_mon;
    always @(negedge clk) begin
        if (rst) begin
            wait_chk = 1'b0;
        end else begin
            if (core_start || core_resume) begin
                if (core_start) n_start++; else n_resume++;
                got_blks.push_back(core_block);
                launched = core_block;
                wait_chk = 1'b1;
                if (exp_blk.size() == 0) begin
                    chk("unexpected_launch", 1'b1, 1'b0);
                end else begin
                    e_mon = exp_blk.pop_front();
                    chk("launch_kind", core_start, e_mon.start);
                    chk("block", core_block, e_mon.blk);
                end
            end
            if (core_done && wait_chk) begin
                chk("block_held", core_block, launched);
                wait_chk = 1'b0;
            end
            if (hash_valid && hash_ready) begin
                last_hash = hash;
                if (exp_hash.size() == 0) chk("unexpected_hash", 1'b1, 1'b0);
                else chk("hash", hash, exp_hash.pop_front());
            end
        end
    end

    // Reference padding + digest; pushes expected blocks and digest.
    task automatic expect_msg(input byte_t msg[$]);
        byte_t        p[$];
        logic [511:0] blk;
        logic [127:0] st;
        logic [63:0]  bl;
        exp_blk_t     e;
        p  = msg;
        bl = 64'(msg.size()) << 3;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(bl[8*i +: 8]);
        st = IV;
        for (int k = 0; k < p.size() / 64; k++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*k+j];
            e.start = (k == 0);
            e.blk   = blk;
            exp_blk.push_back(e);
            st = md5_compress(st, blk);
        end
        exp_hash.push_back(md5_digest(st));
    endtask

    task automatic send_words(input byte_t msg[$]);
        int nw;
        nw = (msg.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            int nb, cyc;
            bit acc;
            d = '0; nb = 0; cyc = 0; acc = 1'b0;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < msg.size()) begin
                    d[31-8*b -: 8] = msg[4*w+b];
                    nb++;
                end else begin
                    d[31-8*b -: 8] = 8'hA5;
                end
            end
            s_valid = 1'b1;
            s_data  = d;
            s_last  = (w == nw - 1);
            s_bytes = 2'(nb);
            while (!acc && cyc < 200) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
                cyc++;
            end
            if (!acc) chk("word_accept", 1'b0, 1'b1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_hash(output bit busy_ok);
        int cyc;
        bit done;
        cyc = 0; done = 1'b0; busy_ok = 1'b1;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (!busy) busy_ok = 1'b0;
            if (hash_valid && hash_ready) done = 1'b1;
        end
        chk("hash_in_time", done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_msg(input byte_t msg[$], output bit busy_ok);
        expect_msg(msg);
        send_words(msg);
        wait_hash(busy_ok);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_t        m[$];
        int           base, ns, nr, cyc;
        bit           ok, stable;
        logic [511:0] b;
        logic [127:0] h0;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_bytes = '0; hash_ready = 1'b1;
`ifdef MD5_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hash_valid", hash_valid, 1'b0);
        chk("rst_hash", hash, 128'h0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_core_resume", core_resume, 1'b0);
        @(posedge clk); #1;

        // "abc"
        m = '{8'h61, 8'h62, 8'h63};
        base = got_blks.size(); ns = n_start; nr = n_resume;
        run_msg(m, ok);
        chk("abc_starts", n_start - ns, 1);
        chk("abc_resumes", n_resume - nr, 0);
        b = got_blks[base];
        chk("abc_block", b, ABC_BLK);
        chk("abc_hash", last_hash, ABC_HASH);

        // 55 bytes: single block with length
        m.delete(); repeat (55) m.push_back(8'h61);
        base = got_blks.size();
        run_msg(m, ok);
        chk("a55_nblk", got_blks.size() - base, 1);
        b = got_blks[base];
        chk("a55_byte55", b[511-8*55 -: 8], 8'h80);
        chk("a55_byte56", b[511-8*56 -: 8], 8'hB8);
        chk("a55_byte57", b[511-8*57 -: 8], 8'h01);

        // 56 bytes: terminator in block 1, length-only block 2
        m.delete(); repeat (56) m.push_back(8'h61);
        base = got_blks.size(); ns = n_start; nr = n_resume;
        run_msg(m, ok);
        chk("a56_starts", n_start - ns, 1);
        chk("a56_resumes", n_resume - nr, 1);
        b = got_blks[base + 1];
        chk("a56_block2", b, A56_BLK2);
        chk("a56_hash", last_hash, A56_HASH);

        // 64 bytes: raw block, then 0x80 + length block
        m.delete(); repeat (64) m.push_back(8'h61);
        base = got_blks.size();
        run_msg(m, ok);
        chk("a64_busy", ok, 1'b1);
        chk("a64_nblk", got_blks.size() - base, 2);
        b = got_blks[base];
        chk("a64_block1", b, {64{8'h61}});
        b = got_blks[base + 1];
        chk("a64_b2_byte0", b[511 -: 8], 8'h80);
        chk("a64_b2_byte56", b[511-8*56 -: 8], 8'h00);
        chk("a64_b2_byte57", b[511-8*57 -: 8], 8'h02);

        // Output backpressure
        hash_ready = 1'b0;
        m = '{8'h61, 8'h62, 8'h63};
        expect_msg(m);
        send_words(m);
        cyc = 0;
        while (!hash_valid && cyc < 500) begin @(negedge clk); cyc++; end
        chk("hold_valid_seen", hash_valid, 1'b1);
        h0 = hash; stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (hash !== h0 || s_ready !== 1'b0 || hash_valid !== 1'b1 || busy !== 1'b1) stable = 1'b0;
        end
        chk("hold_stable", stable, 1'b1);
        chk("hold_hash", h0, ABC_HASH);
        @(posedge clk); #1 hash_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_s_ready", s_ready, 1'b1);
        chk("release_busy", busy, 1'b0);
        chk("release_hash_valid", hash_valid, 1'b0);
        @(posedge clk); #1;

        // Reset in the WAIT of the second block
        m.delete(); repeat (56) m.push_back(8'h61);
        expect_msg(m);
        send_words(m);
        cyc = 0;
        while (!core_resume && cyc < 500) begin @(negedge clk); cyc++; end
        chk("rst_resume_seen", core_resume, 1'b1);
        repeat (10) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_blk.delete(); exp_hash.delete();
        @(negedge clk);
        chk("midrst_s_ready", s_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_hash_valid", hash_valid, 1'b0);
        @(posedge clk); #1;

        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, ok);
        chk("post_rst_abc_hash", last_hash, ABC_HASH);

`ifdef MD5_ABORT_EN
        // Abort while the core is running: no digest is presented
        m = '{8'h61, 8'h62, 8'h63};
        expect_msg(m);
        send_words(m);
        cyc = 0;
        while (!core_start && cyc < 100) begin @(negedge clk); cyc++; end
        repeat (5) @(negedge clk);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        exp_hash.delete();
        cyc = 0;
        while (busy && cyc < 200) begin @(negedge clk); cyc++; end
        chk("abort_idle", busy, 1'b0);
        chk("abort_no_valid", hash_valid, 1'b0);
        @(posedge clk); #1;
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, ok);
        chk("post_abort_hash", last_hash, ABC_HASH);
`endif

        repeat (3) @(posedge clk);
        chk("leftover_blocks", 32'(exp_blk.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
